segment_bus_requester: RTL and testbench
========================================

Name: segment_bus_requester

Overview:
- Master-side counterpart of the segment arbiter. Sits between one bus master's command source and the segment's request/grant pair.
- Accepts a burst command, raises bus_request, and waits for bus_grant. Once granted it issues the burst's beat handshakes, then drops the request for a guaranteed gap so the arbiter can re-arbitrate.
- Detects grant timeout and grant loss mid-burst, and reports completion or error as single-cycle pulses.

Parameters:
BEAT_W, 8, width of beat count/index; bursts of 1..2^BEAT_W beats
TIMEOUT, 64, max cycles in REQ without grant before abort (>=2)
GAP, 1, cycles bus_request held low after each burst (>=1)

Ports:
hclock  input  1  rising-edge clock, shared with arbiter
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  burst command valid
cmd_ready  output  1  block can accept a command
cmd_beats  input  BEAT_W  burst length minus one (0 means 1 beat)
bus_request  output  1  request to segment arbiter
bus_grant  input  1  grant from segment arbiter
beat_valid  output  1  beat offered on segment
beat_ready  input  1  segment accepts beat
beat_last  output  1  current beat is final beat of burst
beat_index  output  BEAT_W  index of current beat, 0-based
done  output  1  one-cycle pulse: burst completed
error  output  1  one-cycle pulse: burst aborted
err_code  output  2  01 timeout, 10 grant lost; held until next error, 00 after reset

Behaviour:
- States: IDLE, REQ, XFER, RELEASE. All state, counters and registered outputs update on posedge hclock.
- Reset (sync, dominates everything):
  - state=IDLE; bus_request=0, beat_valid=0, beat_last=0, beat_index=0, done=0, error=0, err_code=00.
  - cmd_ready=0 in the cycle reset is high; cmd_ready=1 from the first cycle after reset.
  - Reset mid-burst: bus_request low in the next cycle; no done or error pulse.
- IDLE:
  - cmd_ready=1, bus_request=0.
  - cmd_valid&cmd_ready at edge T: latch cmd_beats into len, clear beat_index and the wait counter, go to REQ. bus_request=1 from cycle T+1.
- REQ:
  - bus_request=1, cmd_ready=0, beat_valid=0.
  - bus_grant=1 sampled at edge G: go to XFER; beat_valid=1 from G+1.
  - Otherwise the wait counter increments. Counter==TIMEOUT-1 with no grant: go to RELEASE, pulse error with err_code=01.
  - Grant arriving on the same edge the counter hits TIMEOUT-1 wins: go to XFER, no error.
- XFER:
  - bus_request=1.
  - beat_valid = (state==XFER) & bus_grant. This is combinational gating so a beat is never offered without grant.
  - beat_last = beat_valid & (beat_index==len).
  - Each beat_valid&beat_ready edge increments beat_index.
  - Handshake with beat_last: go to RELEASE, pulse done in the first RELEASE cycle.
  - bus_grant=0 sampled in XFER before the last handshake: abort, go to RELEASE, pulse error with err_code=10, no done. beat_index holds its value for debug until the next command.
  - beat_ready while beat_valid=0 is ignored.
- RELEASE:
  - bus_request=0, cmd_ready=0, beat_valid=0 for exactly GAP cycles, then IDLE.
  - This guarantees the arbiter sees the request drop and re-arbitrates, even if a new command is already pending.
- done and error are registered, mutually exclusive, and one cycle wide.
- Back-to-back bursts: minimum spacing between request deassert and reassert is GAP+1 cycles (RELEASE plus the IDLE accept cycle).
- len=2^BEAT_W-1 (max burst): beat_index must not wrap before beat_last. Width is exactly BEAT_W, no overflow.
- cmd_beats and cmd_valid are ignored outside IDLE.

Test Plan:
- Single beat: reset 2 cycles, cmd_beats=0 accepted at cycle 3, grant tied high -> bus_request high at 4, beat_valid&beat_last at 5 with beat_ready=1, done pulse at 6, bus_request low at 6, cmd_ready=1 at 7.
- 4-beat burst with backpressure: cmd_beats=3, grant at 2nd REQ cycle, beat_ready toggles 1,0,1,0,1,1 -> beat_index 0,1,1,2,2,3, beat_last only on index 3, exactly 4 handshakes, one done.
- Timeout: TIMEOUT=8, grant held 0 -> bus_request high 8 cycles then low, error=1 with err_code=01 once, no beat_valid ever, cmd_ready back after GAP.
- Grant loss: cmd_beats=7, drop bus_grant after 3 handshakes -> beat_valid falls the same cycle, error with err_code=10, no done, bus_request low for GAP cycles.
- Back-to-back with arbiter model (2 requesters, this block at priority 0): continuous cmd_valid -> request low at least GAP cycles between bursts, and the lower-priority master receives a grant within each gap.
- Reset mid-XFER at beat 2 of 8 -> next cycle all outputs 0, state IDLE, no done or error, and a subsequent command completes normally.

Source files
------------

// File: rtl/segment_bus_requester_if.sv
// rtl/segment_bus_requester_if.sv - command, request/grant and beat signals of one segment master
// Purpose: bundles the command source, arbiter request/grant and beat handshake
//          signals that connect a segment_bus_requester to its environment.
// Signals:
//   cmd_valid/cmd_ready/cmd_beats   burst command handshake (cmd_beats = length-1)
//   bus_request/bus_grant           request to and grant from the segment arbiter
//   beat_valid/beat_ready           per-beat handshake on the segment
//   beat_last/beat_index            final-beat flag and 0-based beat number
//   done/error/err_code             completion / abort pulses and sticky error code
// Modports: master = the requester block, slave = command source plus arbiter/segment.
interface segment_bus_requester_if #(
  parameter int BEAT_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [BEAT_W-1:0] cmd_beats;
  logic              bus_request;
  logic              bus_grant;
  logic              beat_valid;
  logic              beat_ready;
  logic              beat_last;
  logic [BEAT_W-1:0] beat_index;
  logic              done;
  logic              error;
  logic [1:0]        err_code;

  modport master (
    input  cmd_valid, cmd_beats, bus_grant, beat_ready,
    output cmd_ready, bus_request, beat_valid, beat_last, beat_index,
    output done, error, err_code
  );

  modport slave (
    output cmd_valid, cmd_beats, bus_grant, beat_ready,
    input  cmd_ready, bus_request, beat_valid, beat_last, beat_index,
    input  done, error, err_code
  );
endinterface

// File: rtl/segment_bus_requester.sv
// rtl/segment_bus_requester.sv - bus master requester: request, burst beats, release gap
// Purpose: accepts a burst command, requests the segment, issues the burst's beats once
//          granted, then drops the request for GAP cycles so the arbiter re-arbitrates.
//          Grant timeout and grant loss abort the burst with a sticky error code.
// Ports:
//   hclock  rising-edge clock shared with the arbiter
//   reset   synchronous active-high reset
//   bus     segment_bus_requester_if.master (command, request/grant, beats, status)
module segment_bus_requester #(
  parameter int BEAT_W  = 8,
  parameter int TIMEOUT = 64,
  parameter int GAP     = 1
) (
  input  logic                    hclock,
  input  logic                    reset,
  segment_bus_requester_if.master bus
);
  localparam int WAIT_W = $clog2(TIMEOUT);
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_RELEASE} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [BEAT_W-1:0] r_len;
  logic [BEAT_W-1:0] r_beat_index;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic              r_done;
  logic              r_error;
  logic [1:0]        r_err_code;

  logic              w_cmd_ready;
  logic              w_beat_valid;
  logic              w_beat_last;
  logic              w_handshake;
  logic              w_done_nxt;
  logic              w_error_nxt;
  logic [1:0]        w_err_code_nxt;

  // Beats are gated by the live grant so nothing is offered after the arbiter withdraws.
  assign w_cmd_ready  = (r_state == S_IDLE) & ~reset;
  assign w_beat_valid = (r_state == S_XFER) & bus.bus_grant;
  assign w_beat_last  = w_beat_valid & (r_beat_index == r_len);
  assign w_handshake  = w_beat_valid & bus.beat_ready;

  always_comb begin
    w_next_state   = r_state;
    w_done_nxt     = 1'b0;
    w_error_nxt    = 1'b0;
    w_err_code_nxt = r_err_code;
    case (r_state)
      S_IDLE: begin
        if (bus.cmd_valid && w_cmd_ready) begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        // A grant on the final wait cycle still wins over the timeout.
        if (bus.bus_grant) begin
          w_next_state = S_XFER;
        end else if (r_wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          w_next_state   = S_RELEASE;
          w_error_nxt    = 1'b1;
          w_err_code_nxt = 2'b01;
        end
      end
      S_XFER: begin
        if (!bus.bus_grant) begin
          w_next_state   = S_RELEASE;
          w_error_nxt    = 1'b1;
          w_err_code_nxt = 2'b10;
        end else if (w_handshake && w_beat_last) begin
          w_next_state = S_RELEASE;
          w_done_nxt   = 1'b1;
        end
      end
      S_RELEASE: begin
        if (r_gap_cnt == GAP_W'(GAP - 1)) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge hclock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_len        <= '0;
      r_beat_index <= '0;
      r_wait_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_code   <= 2'b00;
    end else begin
      r_state    <= w_next_state;
      r_done     <= w_done_nxt;
      r_error    <= w_error_nxt;
      r_err_code <= w_err_code_nxt;
      if (r_state == S_IDLE && w_next_state == S_REQ) begin
        r_len        <= bus.cmd_beats;
        r_beat_index <= '0;
        r_wait_cnt   <= '0;
      end
      if (r_state == S_REQ && !bus.bus_grant) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      // Index stops on the last beat so a maximum-length burst never wraps.
      if (w_handshake && !w_beat_last) begin
        r_beat_index <= r_beat_index + 1'b1;
      end
      if (r_state == S_RELEASE) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end else begin
        r_gap_cnt <= '0;
      end
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.bus_request = (r_state == S_REQ) || (r_state == S_XFER);
  assign bus.beat_valid  = w_beat_valid;
  assign bus.beat_last   = w_beat_last;
  assign bus.beat_index  = r_beat_index;
  assign bus.done        = r_done;
  assign bus.error       = r_error;
  assign bus.err_code    = r_err_code;
endmodule

// File: tb/tb_segment_bus_requester.sv
// tb/tb_segment_bus_requester.sv - self-checking bench for segment_bus_requester
module tb_segment_bus_requester;
  localparam int BW  = 4;
  localparam int TMO = 8;
  localparam int GP  = 2;

  logic hclock = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   exp_code = 0;

  always #5 hclock = ~hclock;

  segment_bus_requester_if #(.BEAT_W(BW)) bus ();

  segment_bus_requester #(.BEAT_W(BW), .TIMEOUT(TMO), .GAP(GP)) dut (
    .hclock(hclock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge hclock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic cmd_noise();
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_beats = BW'($urandom);
  endtask

  // One burst: accept, request with grant arriving after gdelay REQ cycles (timeout
  // if it never arrives in time), beats with random or patterned ready, optional grant
  // withdrawal after drop_after handshakes, then the release gap.
  task automatic burst(input int beats, input int gdelay, input int drop_after,
                       input int ready_pct, input bit use_pat, input logic [31:0] pat_in);
    logic [31:0] rpat;
    bit granted;
    bit done_exp;
    bit err_exp;
    int hs;
    int cyc;
    rpat = pat_in;
    granted = 0;
    done_exp = 0;
    err_exp = 0;
    hs = 0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_beats  = BW'(beats);
    bus.bus_grant  = 1'b0;
    bus.beat_ready = 1'($urandom_range(0, 1));
    settle();
    chk("idle_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    chk("idle_request", 32'(bus.bus_request), 32'(0));
    chk("idle_valid", 32'(bus.beat_valid), 32'(0));
    chk("idle_done", 32'(bus.done), 32'(0));
    chk("idle_error", 32'(bus.error), 32'(0));
    tick();
    for (int k = 0; k < TMO; k++) begin
      bus.bus_grant  = (k >= gdelay);
      bus.beat_ready = 1'($urandom_range(0, 1));
      cmd_noise();
      settle();
      chk("req_request", 32'(bus.bus_request), 32'(1));
      chk("req_cmd_ready", 32'(bus.cmd_ready), 32'(0));
      chk("req_valid", 32'(bus.beat_valid), 32'(0));
      chk("req_pulses", 32'({bus.done, bus.error}), 32'(0));
      tick();
      if (k >= gdelay) begin
        granted = 1;
        break;
      end
    end
    if (granted) begin
      for (cyc = 0; cyc < 500; cyc++) begin
        bit g;
        bit r;
        g = !(drop_after >= 0 && hs >= drop_after);
        if (use_pat) begin
          r = rpat[0];
          rpat = rpat >> 1;
        end else begin
          r = ($urandom_range(1, 100) <= ready_pct);
        end
        bus.bus_grant  = g;
        bus.beat_ready = r;
        cmd_noise();
        settle();
        chk("xfer_request", 32'(bus.bus_request), 32'(1));
        chk("xfer_valid", 32'(bus.beat_valid), 32'(g));
        chk("xfer_last", 32'(bus.beat_last), 32'(g && hs == beats));
        chk("xfer_index", 32'(bus.beat_index), 32'(hs));
        chk("xfer_pulses", 32'({bus.done, bus.error}), 32'(0));
        tick();
        if (!g) begin
          err_exp = 1;
          exp_code = 2;
          break;
        end
        if (r) begin
          if (hs == beats) begin
            done_exp = 1;
            break;
          end
          hs++;
        end
      end
      if (!(done_exp || err_exp)) begin
        total++;
        bad++;
        $error("FAIL xfer_bound observed=%0d expected=<500 cycles", cyc);
      end
    end else begin
      err_exp = 1;
      exp_code = 1;
    end
    for (int g = 0; g < GP; g++) begin
      bus.bus_grant  = 1'($urandom_range(0, 1));
      bus.beat_ready = 1'($urandom_range(0, 1));
      cmd_noise();
      settle();
      chk("gap_request", 32'(bus.bus_request), 32'(0));
      chk("gap_cmd_ready", 32'(bus.cmd_ready), 32'(0));
      chk("gap_valid", 32'(bus.beat_valid), 32'(0));
      chk("gap_done", 32'(bus.done), 32'(g == 0 && done_exp));
      chk("gap_error", 32'(bus.error), 32'(g == 0 && err_exp));
      chk("gap_err_code", 32'(bus.err_code), 32'(exp_code));
      if (err_exp) chk("gap_index_hold", 32'(bus.beat_index), 32'(hs));
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.cmd_valid  = 1'b0;
    bus.cmd_beats  = '0;
    bus.bus_grant  = 1'b0;
    bus.beat_ready = 1'b0;
    tick();
    settle();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    tick();
    settle();
    chk("rst_request", 32'(bus.bus_request), 32'(0));
    chk("rst_valid", 32'(bus.beat_valid), 32'(0));
    chk("rst_last", 32'(bus.beat_last), 32'(0));
    chk("rst_index", 32'(bus.beat_index), 32'(0));
    chk("rst_pulses", 32'({bus.done, bus.error}), 32'(0));
    chk("rst_err_code", 32'(bus.err_code), 32'(0));
    chk("rst_cmd_ready2", 32'(bus.cmd_ready), 32'(0));
    tick();
    reset = 1'b0;

    burst(0, 0, -1, 100, 1'b0, 32'h0);
    burst(3, 1, -1, 0, 1'b1, 32'b110101);
    burst(5, TMO + 3, -1, 100, 1'b0, 32'h0);
    burst(2, 0, -1, 100, 1'b0, 32'h0);
    burst(7, TMO - 1, -1, 100, 1'b0, 32'h0);
    burst(7, 0, 3, 100, 1'b0, 32'h0);
    burst(15, 0, -1, 100, 1'b0, 32'h0);
    burst(15, 2, -1, 60, 1'b0, 32'h0);

    for (int i = 0; i < 40; i++) begin
      int b;
      int d;
      int drop;
      b = $urandom_range(0, 15);
      d = $urandom_range(0, TMO + 1);
      drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, b) : -1;
      burst(b, d, drop, $urandom_range(30, 100), 1'b0, 32'h0);
    end

    bus.cmd_valid  = 1'b1;
    bus.cmd_beats  = BW'(7);
    bus.bus_grant  = 1'b1;
    bus.beat_ready = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    settle();
    chk("mid_index", 32'(bus.beat_index), 32'(2));
    chk("mid_valid", 32'(bus.beat_valid), 32'(1));
    reset = 1'b1;
    settle();
    chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'(0));
    tick();
    reset = 1'b0;
    settle();
    exp_code = 0;
    chk("post_rst_request", 32'(bus.bus_request), 32'(0));
    chk("post_rst_valid", 32'(bus.beat_valid), 32'(0));
    chk("post_rst_index", 32'(bus.beat_index), 32'(0));
    chk("post_rst_pulses", 32'({bus.done, bus.error}), 32'(0));
    chk("post_rst_err_code", 32'(bus.err_code), 32'(0));
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'(1));
    tick();
    burst(4, 1, -1, 80, 1'b0, 32'h0);

    bus.cmd_valid = 1'b0;
    settle();
    chk("end_pulses", 32'({bus.done, bus.error}), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
